// File: rtl/vx_ifetch_tracker_if.sv
// ---------------------------------------------------------------------------
// vx_ifetch_tracker_if
//   Bundles the handshake signals around the fetch tracker: scheduler request,
//   icache request/response, per-warp flush, fetch result and busy.
//
//   master : the surroundings (scheduler, icache, downstream, flush source)
//   slave  : the fetch tracker itself
// ---------------------------------------------------------------------------
interface vx_ifetch_tracker_if #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int NUM_TAGS    = 8,
    parameter int INSTR_WIDTH = 32
);
    localparam int NW_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int TAG_BITS = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

    // scheduler request
    logic                   req_valid;
    logic [NW_BITS-1:0]     req_wid;
    logic [NUM_THREADS-1:0] req_tmask;
    logic [31:0]            req_PC;
    logic                   req_ready;

    // icache request
    logic                   icache_req_valid;
    logic [29:0]            icache_req_addr;
    logic [TAG_BITS-1:0]    icache_req_tag;
    logic                   icache_req_ready;

    // icache response
    logic                   icache_rsp_valid;
    logic [INSTR_WIDTH-1:0] icache_rsp_data;
    logic [TAG_BITS-1:0]    icache_rsp_tag;
    logic                   icache_rsp_ready;

    // branch-redirect flush
    logic                   flush_valid;
    logic [NW_BITS-1:0]     flush_wid;

    // fetch result
    logic                   rsp_valid;
    logic [NW_BITS-1:0]     rsp_wid;
    logic [NUM_THREADS-1:0] rsp_tmask;
    logic [31:0]            rsp_PC;
    logic [INSTR_WIDTH-1:0] rsp_instr;
    logic                   rsp_ready;

    logic                   busy;

    modport master (
        output req_valid, req_wid, req_tmask, req_PC,
        input  req_ready,
        input  icache_req_valid, icache_req_addr, icache_req_tag,
        output icache_req_ready,
        output icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
        input  icache_rsp_ready,
        output flush_valid, flush_wid,
        input  rsp_valid, rsp_wid, rsp_tmask, rsp_PC, rsp_instr,
        output rsp_ready,
        input  busy
    );

    modport slave (
        input  req_valid, req_wid, req_tmask, req_PC,
        output req_ready,
        output icache_req_valid, icache_req_addr, icache_req_tag,
        input  icache_req_ready,
        input  icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
        output icache_rsp_ready,
        input  flush_valid, flush_wid,
        output rsp_valid, rsp_wid, rsp_tmask, rsp_PC, rsp_instr,
        input  rsp_ready,
        output busy
    );
endinterface

// File: rtl/vx_ifetch_tracker.sv
// ---------------------------------------------------------------------------
// vx_ifetch_tracker
//   Multi-warp, multi-outstanding instruction-fetch tracker. Each accepted
//   fetch takes the lowest free tag of a NUM_TAGS-entry table holding
//   wid/tmask/PC. Icache responses may return in any order and are matched by
//   tag, then presented through a single registered output stage. A per-warp
//   flush marks that warp's in-flight entries stale so their responses are
//   swallowed without back-pressure.
//
//   Ports
//     clk    : clock
//     reset  : asynchronous, active-high reset
//     bus    : vx_ifetch_tracker_if.slave (request, icache req/rsp, flush,
//              fetch result, busy)
// ---------------------------------------------------------------------------
module vx_ifetch_tracker #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_THREADS  = 4,
    parameter int NUM_TAGS     = 8,
    parameter int MAX_INFLIGHT = 2,
    parameter int INSTR_WIDTH  = 32
) (
    input  logic                clk,
    input  logic                reset,
    vx_ifetch_tracker_if.slave  bus
);
    localparam int NW_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int TAG_BITS = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam int CNT_BITS = $clog2(MAX_INFLIGHT + 1);

    // ---------------- state ----------------
    logic [NUM_TAGS-1:0]    valid_q, valid_d;
    logic [NUM_TAGS-1:0]    stale_q, stale_d;
    logic [NW_BITS-1:0]     wid_q   [NUM_TAGS];
    logic [NUM_THREADS-1:0] tmask_q [NUM_TAGS];
    logic [31:0]            pc_q    [NUM_TAGS];

    logic [CNT_BITS-1:0]    inflight_q [NUM_WARPS];
    logic [CNT_BITS-1:0]    inflight_d [NUM_WARPS];

    logic                   rsp_valid_q, rsp_valid_d;
    logic [NW_BITS-1:0]     rsp_wid_q,   rsp_wid_d;
    logic [NUM_THREADS-1:0] rsp_tmask_q, rsp_tmask_d;
    logic [31:0]            rsp_pc_q,    rsp_pc_d;
    logic [INSTR_WIDTH-1:0] rsp_instr_q, rsp_instr_d;

    // ---------------- request path ----------------
    logic                any_free;
    logic [TAG_BITS-1:0] alloc_tag;
    logic                alloc_ok;
    logic                req_fire;

    // Free search looks only at registered valid bits, so a tag released this
    // cycle becomes allocatable next cycle. Descending scan -> lowest index wins.
    always_comb begin
        any_free  = 1'b0;
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                any_free  = 1'b1;
                alloc_tag = TAG_BITS'(i);
            end
        end
    end

    assign alloc_ok = any_free
                   && (inflight_q[bus.req_wid] < CNT_BITS'(MAX_INFLIGHT))
                   && !(bus.flush_valid && (bus.flush_wid == bus.req_wid));

    assign bus.icache_req_valid = bus.req_valid && alloc_ok;
    assign bus.icache_req_addr  = bus.req_PC[31:2];
    assign bus.icache_req_tag   = alloc_tag;
    assign bus.req_ready        = alloc_ok && bus.icache_req_ready;
    assign req_fire             = bus.req_valid && bus.req_ready;

    // ---------------- response path ----------------
    logic [TAG_BITS-1:0] rsp_tag;
    logic                rsp_hit;
    logic [NW_BITS-1:0]  rsp_entry_wid;
    logic                rsp_drop;
    logic                out_free;
    logic                rsp_accept;
    logic                rsp_load;
    logic                out_fire;

    assign rsp_tag       = bus.icache_rsp_tag;
    assign rsp_hit       = valid_q[rsp_tag];
    assign rsp_entry_wid = wid_q[rsp_tag];
    // A response is dropped if its entry was flushed earlier or is being
    // flushed right now; such responses never wait on the output stage.
    assign rsp_drop      = stale_q[rsp_tag]
                        || (bus.flush_valid && (rsp_entry_wid == bus.flush_wid));
    assign out_free      = !rsp_valid_q || bus.rsp_ready;
    assign bus.icache_rsp_ready = rsp_drop ? 1'b1 : out_free;
    assign rsp_accept    = bus.icache_rsp_valid && bus.icache_rsp_ready && rsp_hit;
    assign rsp_load      = rsp_accept && !rsp_drop;
    assign out_fire      = rsp_valid_q && bus.rsp_ready;

    // ---------------- tag table next state ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TAGS; gi++) begin : g_entry
            logic alloc_here;
            logic release_here;
            logic flush_here;

            assign alloc_here   = req_fire && (alloc_tag == TAG_BITS'(gi));
            assign release_here = rsp_accept && (rsp_tag == TAG_BITS'(gi));
            assign flush_here   = bus.flush_valid && valid_q[gi]
                               && (wid_q[gi] == bus.flush_wid);

            // Allocation and release never hit the same entry in one cycle:
            // only free entries are allocated, only valid ones released.
            assign valid_d[gi] = alloc_here ? 1'b1 : (release_here ? 1'b0 : valid_q[gi]);
            assign stale_d[gi] = alloc_here ? 1'b0 : (flush_here   ? 1'b1 : stale_q[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            stale_q <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                wid_q[i]   <= '0;
                tmask_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            valid_q <= valid_d;
            stale_q <= stale_d;
            if (req_fire) begin
                wid_q[alloc_tag]   <= bus.req_wid;
                tmask_q[alloc_tag] <= bus.req_tmask;
                pc_q[alloc_tag]    <= bus.req_PC;
            end
        end
    end

    // ---------------- per-warp inflight counters ----------------
    // Increment only happens below MAX_INFLIGHT and decrement only for a live
    // entry of that warp, so the counters cannot wrap.
    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            logic inc;
            logic dec;

            assign inc = req_fire   && (bus.req_wid   == NW_BITS'(gi));
            assign dec = rsp_accept && (rsp_entry_wid == NW_BITS'(gi));

            assign inflight_d[gi] = (inc && !dec) ? inflight_q[gi] + CNT_BITS'(1)
                                  : (dec && !inc) ? inflight_q[gi] - CNT_BITS'(1)
                                  : inflight_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_WARPS; i++) inflight_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_WARPS; i++) inflight_q[i] <= inflight_d[i];
        end
    end

    // ---------------- output stage ----------------
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_wid_d   = rsp_wid_q;
        rsp_tmask_d = rsp_tmask_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_instr_d = rsp_instr_q;
        if (rsp_load) begin
            // rsp_load implies the register is empty or draining this cycle.
            rsp_valid_d = 1'b1;
            rsp_wid_d   = rsp_entry_wid;
            rsp_tmask_d = tmask_q[rsp_tag];
            rsp_pc_d    = pc_q[rsp_tag];
            rsp_instr_d = bus.icache_rsp_data;
        end else if (out_fire) begin
            rsp_valid_d = 1'b0;
        end else if (bus.flush_valid && rsp_valid_q && (rsp_wid_q == bus.flush_wid)) begin
            // Held result of a redirected warp is discarded.
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_wid_q   <= '0;
            rsp_tmask_q <= '0;
            rsp_pc_q    <= '0;
            rsp_instr_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_wid_q   <= rsp_wid_d;
            rsp_tmask_q <= rsp_tmask_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_instr_q <= rsp_instr_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_wid   = rsp_wid_q;
    assign bus.rsp_tmask = rsp_tmask_q;
    assign bus.rsp_PC    = rsp_pc_q;
    assign bus.rsp_instr = rsp_instr_q;
    assign bus.busy      = (|valid_q) || rsp_valid_q;

    // A response for a tag that is not live is ignored by the logic above;
    // it indicates an icache protocol error.
    rsp_tag_live_a: assert property (@(posedge clk) disable iff (reset)
        bus.icache_rsp_valid |-> rsp_hit);

endmodule

// File: tb/tb_vx_ifetch_tracker.sv
module tb_vx_ifetch_tracker;
    localparam int NUM_WARPS    = 4;
    localparam int NUM_THREADS  = 4;
    localparam int NUM_TAGS     = 8;
    localparam int MAX_INFLIGHT = 2;
    localparam int INSTR_WIDTH  = 32;

    logic clk;
    logic reset;

    vx_ifetch_tracker_if #(
        .NUM_WARPS(NUM_WARPS), .NUM_THREADS(NUM_THREADS),
        .NUM_TAGS(NUM_TAGS), .INSTR_WIDTH(INSTR_WIDTH)
    ) bus ();

    vx_ifetch_tracker #(
        .NUM_WARPS(NUM_WARPS), .NUM_THREADS(NUM_THREADS), .NUM_TAGS(NUM_TAGS),
        .MAX_INFLIGHT(MAX_INFLIGHT), .INSTR_WIDTH(INSTR_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          wid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    // reference tag table
    bit          m_valid [NUM_TAGS];
    bit          m_stale [NUM_TAGS];
    int          m_wid   [NUM_TAGS];
    logic [3:0]  m_tmask [NUM_TAGS];
    logic [31:0] m_pc    [NUM_TAGS];
    int          m_cnt   [NUM_WARPS];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < NUM_TAGS; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_TAGS; i++) begin
            m_valid[i] = 0;
            m_stale[i] = 0;
        end
        for (int w = 0; w < NUM_WARPS; w++) m_cnt[w] = 0;
    endtask

    task automatic set_flush(input int w);
        bus.flush_valid = 1'b1;
        bus.flush_wid   = 2'(w);
        for (int i = 0; i < NUM_TAGS; i++)
            if (m_valid[i] && m_wid[i] == w) m_stale[i] = 1;
    endtask

    task automatic clear_flush();
        bus.flush_valid = 1'b0;
    endtask

    // One request cycle; expected acceptance and tag come from the reference table.
    task automatic issue(input int wid, input logic [31:0] pc, input logic [3:0] tm);
        int t;
        bit ok;
        t  = lowest_free();
        ok = (t >= 0) && (m_cnt[wid] < MAX_INFLIGHT)
             && !(bus.flush_valid && int'(bus.flush_wid) == wid);
        bus.req_valid = 1'b1;
        bus.req_wid   = 2'(wid);
        bus.req_PC    = pc;
        bus.req_tmask = tm;
        @(negedge clk);
        check_eq("req_ready", bus.req_ready, ok);
        check_eq("icache_req_valid", bus.icache_req_valid, ok);
        if (ok) begin
            check_eq("icache_req_addr", bus.icache_req_addr, pc[31:2]);
            check_eq("icache_req_tag", bus.icache_req_tag, t);
        end
        $display("REQ wid=%0d pc=%h tmask=%h accepted=%0d tag=%0d", wid, pc, tm, ok, t);
        @(posedge clk);
        #1;
        if (ok) begin
            m_valid[t] = 1;
            m_stale[t] = 0;
            m_wid[t]   = wid;
            m_tmask[t] = tm;
            m_pc[t]    = pc;
            m_cnt[wid]++;
        end
        bus.req_valid = 1'b0;
    endtask

    // One icache response cycle; non-dropped accepted responses go to the scoreboard.
    task automatic respond(input int tag, input logic [31:0] data, input bit exp_ready);
        bit   accept;
        bit   drop;
        exp_t e;
        bus.icache_rsp_valid = 1'b1;
        bus.icache_rsp_tag   = 3'(tag);
        bus.icache_rsp_data  = data;
        @(negedge clk);
        check_eq("icache_rsp_ready", bus.icache_rsp_ready, exp_ready);
        accept = exp_ready && m_valid[tag];
        drop   = m_stale[tag] || (bus.flush_valid && int'(bus.flush_wid) == m_wid[tag]);
        if (accept && !drop) begin
            e.wid   = m_wid[tag];
            e.tmask = m_tmask[tag];
            e.pc    = m_pc[tag];
            e.instr = data;
            sb.push_back(e);
        end
        $display("ICRSP tag=%0d data=%h accepted=%0d dropped=%0d", tag, data, accept, accept && drop);
        @(posedge clk);
        #1;
        if (accept) begin
            m_valid[tag] = 0;
            m_cnt[m_wid[tag]]--;
        end
        bus.icache_rsp_valid = 1'b0;
    endtask

    // Output monitor: every transfer is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                check_eq("rsp_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("rsp_wid", bus.rsp_wid, e.wid);
                check_eq("rsp_tmask", bus.rsp_tmask, e.tmask);
                check_eq("rsp_PC", bus.rsp_PC, e.pc);
                check_eq("rsp_instr", bus.rsp_instr, e.instr);
                $display("RSP wid=%0d pc=%h instr=%h", bus.rsp_wid, bus.rsp_PC, bus.rsp_instr);
            end
        end
    end

    initial begin
        reset                = 1'b1;
        bus.req_valid        = 1'b0;
        bus.req_wid          = '0;
        bus.req_tmask        = '0;
        bus.req_PC           = '0;
        bus.icache_req_ready = 1'b1;
        bus.icache_rsp_valid = 1'b0;
        bus.icache_rsp_data  = '0;
        bus.icache_rsp_tag   = '0;
        bus.flush_valid      = 1'b0;
        bus.flush_wid        = '0;
        bus.rsp_ready        = 1'b1;
        model_reset();

        // ---- reset state ----
        @(negedge clk);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_instr", bus.rsp_instr, 0);
        check_eq("rst_icache_req_valid", bus.icache_req_valid, 0);
        step();
        reset = 1'b0;
        step();

        // ---- single fetch ----
        issue(1, 32'h8000_0000, 4'hF);
        step();
        respond(0, 32'h0000_0013, 1);
        check_eq("lat_rsp_valid", bus.rsp_valid, 1);
        step();
        check_eq("single_busy_low", bus.busy, 0);

        // ---- out-of-order responses ----
        issue(0, 32'h0000_0100, 4'h1);
        issue(1, 32'h0000_0200, 4'h3);
        respond(1, 32'h0000_20AA, 1);
        respond(0, 32'h0000_10BB, 1);
        step();

        // ---- per-warp limit and tag reuse ----
        issue(0, 32'h0000_0300, 4'h1);
        issue(0, 32'h0000_0304, 4'h1);
        issue(0, 32'h0000_0308, 4'h1);
        respond(0, 32'h0000_3000, 1);
        issue(0, 32'h0000_0308, 4'h1);
        respond(1, 32'h0000_3004, 1);
        respond(0, 32'h0000_3008, 1);
        step();

        // ---- fill every tag ----
        for (int w = 0; w < NUM_WARPS; w++) begin
            issue(w, 32'h0000_1000 + 32'(w * 16), 4'(w + 1));
            issue(w, 32'h0000_1004 + 32'(w * 16), 4'(w + 1));
        end
        for (int w = 0; w < NUM_WARPS; w++) issue(w, 32'h0000_1F00, 4'hF);
        for (int t = NUM_TAGS - 1; t >= 0; t--) respond(t, 32'h0000_D000 + 32'(t), 1);
        step();
        check_eq("fill_busy_low", bus.busy, 0);

        // ---- backpressure ----
        bus.rsp_ready = 1'b0;
        issue(0, 32'h0000_0400, 4'h1);
        issue(1, 32'h0000_0404, 4'h2);
        respond(0, 32'h0000_AAA0, 1);
        check_eq("bp_rsp_valid", bus.rsp_valid, 1);
        check_eq("bp_rsp_instr", bus.rsp_instr, 32'h0000_AAA0);
        respond(1, 32'h0000_AAA1, 0);
        check_eq("bp_hold_instr", bus.rsp_instr, 32'h0000_AAA0);
        step();
        check_eq("bp_hold_pc", bus.rsp_PC, 32'h0000_0400);
        bus.rsp_ready = 1'b1;
        respond(1, 32'h0000_AAA1, 1);
        check_eq("bp_drain_instr", bus.rsp_instr, 32'h0000_AAA1);
        step();
        check_eq("bp_drain_empty", bus.rsp_valid, 0);

        // ---- flush of warp 2 while warp 3 is in flight ----
        bus.rsp_ready = 1'b0;
        issue(2, 32'h0000_0500, 4'h4);
        issue(2, 32'h0000_0504, 4'h4);
        issue(3, 32'h0000_0600, 4'h8);
        issue(3, 32'h0000_0604, 4'h8);
        respond(2, 32'h0000_600D, 1);
        set_flush(2);
        issue(2, 32'h0000_0508, 4'h4);
        respond(0, 32'h0000_BAD0, 1);
        clear_flush();
        respond(1, 32'h0000_BAD1, 1);
        check_eq("flush_keep_valid", bus.rsp_valid, 1);
        check_eq("flush_keep_wid", bus.rsp_wid, 3);
        check_eq("flush_keep_instr", bus.rsp_instr, 32'h0000_600D);
        check_eq("flush_busy_live", bus.busy, 1);
        bus.rsp_ready = 1'b1;
        step();
        respond(3, 32'h0000_600E, 1);
        step();
        check_eq("flush_busy_low", bus.busy, 0);
        issue(2, 32'h0000_0510, 4'h4);
        issue(2, 32'h0000_0514, 4'h4);
        respond(1, 32'h0000_5140, 1);
        respond(0, 32'h0000_5100, 1);
        step();

        // ---- flush clears a held output; a same-cycle transfer still counts ----
        bus.rsp_ready = 1'b0;
        issue(1, 32'h0000_0700, 4'h2);
        respond(0, 32'h0000_7000, 1);
        check_eq("oflush_held", bus.rsp_valid, 1);
        set_flush(1);
        step();
        clear_flush();
        check_eq("oflush_cleared", bus.rsp_valid, 0);
        void'(sb.pop_back());   // that result was discarded by the flush
        issue(1, 32'h0000_0704, 4'h2);
        respond(0, 32'h0000_7040, 1);
        bus.rsp_ready = 1'b1;
        set_flush(1);
        step();
        clear_flush();
        check_eq("oflush_xfer_empty", bus.rsp_valid, 0);
        check_eq("oflush_busy_low", bus.busy, 0);

        // ---- reset with fetches outstanding ----
        for (int w = 0; w < NUM_WARPS; w++) issue(w, 32'h0000_0800 + 32'(w * 4), 4'hF);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", bus.busy, 0);
        check_eq("mid_rst_rsp_valid", bus.rsp_valid, 0);
        model_reset();
        step();
        reset = 1'b0;
        issue(0, 32'h0000_0900, 4'h1);
        issue(0, 32'h0000_0904, 4'h1);
        issue(0, 32'h0000_0908, 4'h1);
        respond(0, 32'h0000_9000, 1);
        respond(1, 32'h0000_9004, 1);
        step();
        check_eq("end_busy_low", bus.busy, 0);
        check_eq("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound on the run.
    initial begin
        #100000;
        $display("FAIL timeout reached t=%0t", $time);
        $fatal(1, "timeout");
    end
endmodule
